exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 int_i  in  6  raw hardware interrupt lines; asynchronous to clk.
REQ-005 mem_valid_i  in  1  a real instruction occupies MEM this cycle.
REQ-006 mem_except_i  in  9  per-instruction flags: [0] AdEL-fetch, [1] AdEL-load, [2] AdES, [3] syscall, [4] break, [5] RI, [6] Ov, [7] trap, [8] eret.
REQ-007 mem_pc_i  in  32  PC of the MEM instruction.
REQ-008 mem_is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
REQ-009 mem_bad_addr_i  in  32  data address of the MEM load/store.
REQ-010 cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  forwarded CP0 values.
REQ-011 int_sync_o  out  6  synchronised interrupt lines; drives the CP0 int input.
REQ-012 excepttype_o  out  32  encoded exception code to CP0.
REQ-013 current_inst_addr_o, bad_addr_o  out  32 each  to CP0.
REQ-014 is_in_delayslot_o  out  1  to CP0.
REQ-015 flush_o  out  1  pipeline flush.
REQ-016 new_pc_o  out  32  fetch redirect target; valid while flush_o=1.

Function
REQ-017 int_i SHALL pass through a 2-flop synchroniser; int_sync_o is the second-stage output, so latency is 2 cycles.
REQ-018 Pending interrupt condition: ({int_sync_o, cp0_cause_i[9:8]} & cp0_status_i[15:8]) != 0, status[0]=1 and status[1]=0.
REQ-019 Detection SHALL occur only in state IDLE and only when mem_valid_i=1.
REQ-020 Priority, highest first: interrupt, AdEL-fetch, RI, Ov, trap, syscall, break, AdEL-load, AdES, eret.
REQ-021 Codes: int 0x1, AdEL 0x4, AdES 0x5, syscall 0x8, break 0x9, RI 0xa, Ov 0xc, trap 0xd, eret 0xe.
REQ-022 FSM states: IDLE, COMMIT, DRAIN.
- IDLE->COMMIT on detection.
- COMMIT->DRAIN unconditionally.
- DRAIN->IDLE unconditionally.
REQ-023 On IDLE->COMMIT, the block SHALL register the code, mem_pc_i, mem_is_in_delayslot_i and the bad address.
- Bad address is mem_pc_i for AdEL-fetch and mem_bad_addr_i otherwise.
REQ-024 In COMMIT, excepttype_o SHALL equal the registered code, with exactly one pulse per exception; in IDLE and DRAIN, excepttype_o SHALL be 0.
REQ-025 flush_o SHALL be 1 in COMMIT and DRAIN, and 0 in IDLE.
REQ-026 new_pc_o SHALL be:
- cp0_epc_i sampled at detection, for eret;
- 32'hBFC00380, for all other codes;
- 0 in IDLE.
REQ-027 current_inst_addr_o, bad_addr_o and is_in_delayslot_o SHALL hold their registered values through COMMIT and DRAIN.
REQ-028 Exception flags and interrupts arriving in COMMIT or DRAIN SHALL be ignored, since those instructions are flushed.
- A level interrupt still pending on return to IDLE is taken then.
REQ-029 When mem_valid_i=0, no exception is taken; an interrupt waits for the next valid instruction.
REQ-030 When an interrupt and an instruction flag coincide, the code SHALL be 0x1 and EPC SHALL be the interrupted instruction's PC.

Reset
REQ-031 rst=0 SHALL immediately force all of the following, independent of clk:
- state IDLE;
- synchroniser flops 0;
- excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o all 0;
- is_in_delayslot_o 0, flush_o 0.
REQ-032 Reset asserted in COMMIT or DRAIN SHALL abort the sequence; after release the block starts in IDLE with no pending output.

Verification
REQ-033 Syscall: mem_except_i=0x008, mem_pc_i=0x80000010, valid -> next cycle excepttype_o=0x8, current_inst_addr_o=0x80000010, flush_o=1 for 2 cycles, new_pc_o=0xBFC00380.
REQ-034 Interrupt: status=0x0000FF01, int_i[2] rises -> int_sync_o[2] high 2 cycles later; on the next valid instruction, code 0x1; with status[1]=1, no exception.
REQ-035 Priority: flags RI|Ov|AdEL-load together with an interrupt pending -> code 0x1; the same flags without the interrupt -> code 0xa.
REQ-036 AdEL-fetch with mem_pc_i=0x80000003, delay slot=1 -> code 0x4, bad_addr_o=0x80000003, is_in_delayslot_o=1.
REQ-037 Eret with cp0_epc_i=0x80001234 -> code 0xe, new_pc_o=0x80001234; a syscall presented during DRAIN is ignored.
REQ-038 Reset asserted mid-COMMIT -> all outputs 0 within the same cycle; state IDLE after release.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Bundle of MEM-stage, CP0 and redirect signals exchanged with the exception controller.
// The slave view belongs to the controller; the master view belongs to the pipeline/CP0 side.
interface exception_ctrl_if;
  logic [5:0]  int_i;
  logic        mem_valid_i;
  logic [8:0]  mem_except_i;
  logic [31:0] mem_pc_i;
  logic        mem_is_in_delayslot_i;
  logic [31:0] mem_bad_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic [31:0] bad_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  int_i, mem_valid_i, mem_except_i, mem_pc_i, mem_is_in_delayslot_i,
           mem_bad_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    output int_sync_o, excepttype_o, current_inst_addr_o, bad_addr_o,
           is_in_delayslot_o, flush_o, new_pc_o
  );

  modport master (
    output int_i, mem_valid_i, mem_except_i, mem_pc_i, mem_is_in_delayslot_i,
           mem_bad_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  int_sync_o, excepttype_o, current_inst_addr_o, bad_addr_o,
           is_in_delayslot_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: synchronises interrupts, prioritises exception flags and
// runs a three-state commit sequence that pulses the code to CP0 and flushes the pipeline.
module exception_ctrl (
  input  logic            clk,
  input  logic            rst,
  exception_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [4:0]  CODE_NONE  = 5'h00;
  localparam logic [4:0]  CODE_INT   = 5'h01;
  localparam logic [4:0]  CODE_ADEL  = 5'h04;
  localparam logic [4:0]  CODE_ADES  = 5'h05;
  localparam logic [4:0]  CODE_SYS   = 5'h08;
  localparam logic [4:0]  CODE_BP    = 5'h09;
  localparam logic [4:0]  CODE_RI    = 5'h0a;
  localparam logic [4:0]  CODE_OV    = 5'h0c;
  localparam logic [4:0]  CODE_TRAP  = 5'h0d;
  localparam logic [4:0]  CODE_ERET  = 5'h0e;

  state_t      r_state;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic [31:0] r_bad;
  logic [31:0] r_new_pc;
  logic        r_ds;
  logic        r_flush;

  logic        w_int_pending;
  logic [4:0]  w_code;
  logic [31:0] w_bad;
  logic        w_detect;
  logic        w_unused_bits;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 6'd0;
      r_sync2 <= 6'd0;
    end else begin
      r_sync1 <= bus.int_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_int_pending = (|({r_sync2, bus.cp0_cause_i[9:8]} & bus.cp0_status_i[15:8]))
                         && bus.cp0_status_i[0] && !bus.cp0_status_i[1];

  // Fixed-priority encode of the pending interrupt and instruction flags
  always_comb begin
    w_code = CODE_NONE;
    w_bad  = bus.mem_bad_addr_i;
    if (w_int_pending) begin
      w_code = CODE_INT;
    end else if (bus.mem_except_i[0]) begin
      w_code = CODE_ADEL;
      w_bad  = bus.mem_pc_i;
    end else if (bus.mem_except_i[5]) begin
      w_code = CODE_RI;
    end else if (bus.mem_except_i[6]) begin
      w_code = CODE_OV;
    end else if (bus.mem_except_i[7]) begin
      w_code = CODE_TRAP;
    end else if (bus.mem_except_i[3]) begin
      w_code = CODE_SYS;
    end else if (bus.mem_except_i[4]) begin
      w_code = CODE_BP;
    end else if (bus.mem_except_i[1]) begin
      w_code = CODE_ADEL;
    end else if (bus.mem_except_i[2]) begin
      w_code = CODE_ADES;
    end else if (bus.mem_except_i[8]) begin
      w_code = CODE_ERET;
    end else begin
      w_code = CODE_NONE;
    end
  end

  assign w_detect = bus.mem_valid_i && (w_code != CODE_NONE);

  // Commit sequencer; capture happens only on the IDLE->COMMIT step so later flags are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_code   <= 5'd0;
      r_pc     <= 32'd0;
      r_bad    <= 32'd0;
      r_new_pc <= 32'd0;
      r_ds     <= 1'b0;
      r_flush  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_detect) begin
            r_state  <= COMMIT;
            r_code   <= w_code;
            r_pc     <= bus.mem_pc_i;
            r_bad    <= w_bad;
            r_ds     <= bus.mem_is_in_delayslot_i;
            r_flush  <= 1'b1;
            r_new_pc <= (w_code == CODE_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
          end else begin
            r_code   <= 5'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'd0;
          end
        end
        COMMIT: begin
          r_state <= DRAIN;
          r_code  <= 5'd0;
          r_flush <= 1'b1;
        end
        DRAIN: begin
          r_state  <= IDLE;
          r_code   <= 5'd0;
          r_flush  <= 1'b0;
          r_new_pc <= 32'd0;
        end
        default: begin
          r_state  <= IDLE;
          r_code   <= 5'd0;
          r_flush  <= 1'b0;
          r_new_pc <= 32'd0;
        end
      endcase
    end
  end

  assign bus.int_sync_o          = r_sync2;
  assign bus.excepttype_o        = {27'd0, r_code};
  assign bus.current_inst_addr_o = r_pc;
  assign bus.bad_addr_o          = r_bad;
  assign bus.is_in_delayslot_o   = r_ds;
  assign bus.flush_o             = r_flush;
  assign bus.new_pc_o            = r_new_pc;

  assign w_unused_bits = ^{bus.cp0_cause_i[31:10], bus.cp0_cause_i[7:0],
                           bus.cp0_status_i[31:16], bus.cp0_status_i[7:2]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: expected commits are queued as stimulus is driven
// and popped when the controller pulses an exception code.
module tb_exception_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exception_ctrl_if bus ();
  exception_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] bad;
    logic [31:0] npc;
    logic        ds;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  task automatic idle_inputs();
    bus.mem_valid_i  = 1'b0;
    bus.mem_except_i = 9'd0;
  endtask

  task automatic issue(input logic [8:0] f, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
    bus.mem_valid_i           = 1'b1;
    bus.mem_except_i          = f;
    bus.mem_pc_i              = pc;
    bus.mem_is_in_delayslot_i = ds;
    bus.mem_bad_addr_i        = bad;
  endtask

  // waits (bounded) for the next exception pulse; cyc is the number of cycles taken
  task automatic wait_commit(output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      idle_inputs();
      if (bus.excepttype_o !== 32'd0) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_tests++;
    if ({bus.int_sync_o, bus.excepttype_o, bus.current_inst_addr_o, bus.bad_addr_o,
         bus.is_in_delayslot_o, bus.flush_o, bus.new_pc_o} !== 136'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got exc=%h flush=%b npc=%h, required all zero",
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o, bus.new_pc_o} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got exc=%h flush=%b npc=%h, required 0/0/0",
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
  endtask

  task automatic test_syscall();
    bit seen; int cyc; exp_t e;
    issue(9'h008, 32'h8000_0010, 1'b0, 32'h1111_2222);
    sb_q.push_back('{code: 32'h8, pc: 32'h8000_0010, bad: 32'h1111_2222, npc: VEC, ds: 1'b0});
    wait_commit(seen, cyc);
    n_tests++;
    if (!seen || cyc != 1 || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL syscall_latency: seen=%0d cycles=%0d, required pulse after 1 cycle", seen, cyc);
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if ({bus.excepttype_o, bus.current_inst_addr_o, bus.bad_addr_o, bus.new_pc_o,
           bus.is_in_delayslot_o, bus.flush_o} !== {e.code, e.pc, e.bad, e.npc, e.ds, 1'b1}) begin
        n_fail++;
        $display("FAIL syscall_commit: got code=%h pc=%h npc=%h flush=%b, required %h %h %h 1",
                 bus.excepttype_o, bus.current_inst_addr_o, bus.new_pc_o, bus.flush_o,
                 e.code, e.pc, e.npc);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o, bus.current_inst_addr_o, bus.new_pc_o} !==
        {32'd0, 1'b1, 32'h8000_0010, VEC}) begin
      n_fail++;
      $display("FAIL syscall_drain: got code=%h flush=%b pc=%h npc=%h, required 0 1 80000010 %h",
               bus.excepttype_o, bus.flush_o, bus.current_inst_addr_o, bus.new_pc_o, VEC);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o, bus.new_pc_o} !== 65'd0) begin
      n_fail++;
      $display("FAIL syscall_idle: got code=%h flush=%b npc=%h, required 0 0 0",
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
  endtask

  task automatic test_interrupt();
    bit seen; int cyc; exp_t e; int bad_cnt;
    bus.cp0_status_i = 32'h0000_FF01;
    bus.int_i        = 6'b000100;
    @(negedge clk);
    n_tests++;
    if (bus.int_sync_o !== 6'd0) begin
      n_fail++;
      $display("FAIL int_sync_stage1: got %b, required 000000", bus.int_sync_o);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.int_sync_o, bus.flush_o} !== {6'b000100, 1'b0}) begin
      n_fail++;
      $display("FAIL int_sync_stage2: got sync=%b flush=%b, required 000100 0",
               bus.int_sync_o, bus.flush_o);
    end
    @(negedge clk);
    n_tests++;
    if (bus.flush_o !== 1'b0) begin
      n_fail++;
      $display("FAIL int_waits_for_valid: got flush=%b, required 0", bus.flush_o);
    end
    issue(9'h000, 32'h8000_0100, 1'b0, 32'h0);
    sb_q.push_back('{code: 32'h1, pc: 32'h8000_0100, bad: 32'h0, npc: VEC, ds: 1'b0});
    wait_commit(seen, cyc);
    n_tests++;
    if (!seen || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL int_commit_timeout: seen=%0d, required an exception pulse", seen);
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if ({bus.excepttype_o, bus.current_inst_addr_o, bus.new_pc_o} !== {e.code, e.pc, e.npc}) begin
        n_fail++;
        $display("FAIL int_commit: got code=%h pc=%h npc=%h, required %h %h %h",
                 bus.excepttype_o, bus.current_inst_addr_o, bus.new_pc_o, e.code, e.pc, e.npc);
      end
    end
    @(negedge clk);
    @(negedge clk);
    bus.cp0_status_i = 32'h0000_FF03;
    issue(9'h000, 32'h8000_0104, 1'b0, 32'h0);
    bad_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      if (bus.flush_o !== 1'b0) bad_cnt++;
    end
    n_tests++;
    if (bad_cnt != 0) begin
      n_fail++;
      $display("FAIL int_masked_by_exl: flush seen in %0d cycles, required 0", bad_cnt);
    end
    bus.int_i        = 6'd0;
    bus.cp0_status_i = 32'h0000_FF01;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [8:0]  flags [8];
    logic        intr  [8];
    logic [31:0] code  [8];
    bit seen; int cyc; exp_t e;
    flags[0] = 9'h062; intr[0] = 1'b1; code[0] = 32'h1;
    flags[1] = 9'h062; intr[1] = 1'b0; code[1] = 32'ha;
    flags[2] = 9'h0c0; intr[2] = 1'b0; code[2] = 32'hc;
    flags[3] = 9'h088; intr[3] = 1'b0; code[3] = 32'hd;
    flags[4] = 9'h018; intr[4] = 1'b0; code[4] = 32'h8;
    flags[5] = 9'h016; intr[5] = 1'b0; code[5] = 32'h9;
    flags[6] = 9'h106; intr[6] = 1'b0; code[6] = 32'h4;
    flags[7] = 9'h104; intr[7] = 1'b0; code[7] = 32'h5;
    bus.cp0_status_i = 32'h0000_FF01;
    for (int i = 0; i < 8; i++) begin
      bus.cp0_cause_i = intr[i] ? 32'h0000_0100 : 32'h0;
      issue(flags[i], 32'h8000_0200 + 32'(i * 4), 1'b0, 32'h0000_1000 + 32'(i));
      sb_q.push_back('{code: code[i], pc: 32'h8000_0200 + 32'(i * 4),
                       bad: 32'h0000_1000 + 32'(i), npc: VEC, ds: 1'b0});
      wait_commit(seen, cyc);
      n_tests++;
      if (!seen || sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL priority_%0d_timeout: no exception pulse", i);
      end else begin
        e = sb_q.pop_front();
        n_tests++;
        if ({bus.excepttype_o, bus.current_inst_addr_o, bus.bad_addr_o, bus.new_pc_o} !==
            {e.code, e.pc, e.bad, e.npc}) begin
          n_fail++;
          $display("FAIL priority_%0d: got code=%h pc=%h bad=%h, required %h %h %h",
                   i, bus.excepttype_o, bus.current_inst_addr_o, bus.bad_addr_o,
                   e.code, e.pc, e.bad);
        end
      end
      bus.cp0_cause_i = 32'h0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_adel_fetch();
    bit seen; int cyc; exp_t e;
    issue(9'h003, 32'h8000_0003, 1'b1, 32'hDEAD_0000);
    sb_q.push_back('{code: 32'h4, pc: 32'h8000_0003, bad: 32'h8000_0003, npc: VEC, ds: 1'b1});
    wait_commit(seen, cyc);
    n_tests++;
    if (!seen || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL adel_fetch_timeout: no exception pulse");
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if ({bus.excepttype_o, bus.bad_addr_o, bus.is_in_delayslot_o, bus.current_inst_addr_o} !==
          {e.code, e.bad, e.ds, e.pc}) begin
        n_fail++;
        $display("FAIL adel_fetch: got code=%h bad=%h ds=%b, required %h %h %b",
                 bus.excepttype_o, bus.bad_addr_o, bus.is_in_delayslot_o, e.code, e.bad, e.ds);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.bad_addr_o, bus.is_in_delayslot_o, bus.flush_o} !== {32'h8000_0003, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL adel_fetch_hold: got bad=%h ds=%b flush=%b, required 80000003 1 1",
               bus.bad_addr_o, bus.is_in_delayslot_o, bus.flush_o);
    end
    @(negedge clk);
  endtask

  task automatic test_eret();
    bit seen; int cyc; exp_t e;
    bus.cp0_epc_i = 32'h8000_1234;
    issue(9'h100, 32'h8000_0300, 1'b0, 32'h0);
    sb_q.push_back('{code: 32'he, pc: 32'h8000_0300, bad: 32'h0, npc: 32'h8000_1234, ds: 1'b0});
    wait_commit(seen, cyc);
    bus.cp0_epc_i = 32'h0;
    n_tests++;
    if (!seen || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL eret_timeout: no exception pulse");
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if ({bus.excepttype_o, bus.new_pc_o} !== {e.code, e.npc}) begin
        n_fail++;
        $display("FAIL eret_commit: got code=%h npc=%h, required %h %h",
                 bus.excepttype_o, bus.new_pc_o, e.code, e.npc);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.new_pc_o, bus.flush_o} !== {32'h8000_1234, 1'b1}) begin
      n_fail++;
      $display("FAIL eret_epc_held: got npc=%h flush=%b, required 80001234 1",
               bus.new_pc_o, bus.flush_o);
    end
    issue(9'h008, 32'h8000_0304, 1'b0, 32'h0);
    @(negedge clk);
    idle_inputs();
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o, bus.new_pc_o} !== 65'd0) begin
      n_fail++;
      $display("FAIL eret_drain_ignore: got code=%h flush=%b npc=%h, required 0 0 0",
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o} !== 33'd0) begin
      n_fail++;
      $display("FAIL eret_drain_ignore2: got code=%h flush=%b, required 0 0",
               bus.excepttype_o, bus.flush_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x_code [6];
    logic        x_fl   [6];
    exp_t e;
    x_code[0] = 32'h8; x_code[1] = 32'h0; x_code[2] = 32'h0;
    x_code[3] = 32'h8; x_code[4] = 32'h0; x_code[5] = 32'h0;
    x_fl[0] = 1'b1; x_fl[1] = 1'b1; x_fl[2] = 1'b0;
    x_fl[3] = 1'b1; x_fl[4] = 1'b1; x_fl[5] = 1'b0;
    issue(9'h008, 32'h8000_0400, 1'b0, 32'h0);
    sb_q.push_back('{code: 32'h8, pc: 32'h8000_0400, bad: 32'h0, npc: VEC, ds: 1'b0});
    sb_q.push_back('{code: 32'h8, pc: 32'h8000_0400, bad: 32'h0, npc: VEC, ds: 1'b0});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.excepttype_o, bus.flush_o} !== {x_code[c], x_fl[c]}) begin
        n_fail++;
        $display("FAIL b2b_cycle_%0d: got code=%h flush=%b, required %h %b",
                 c, bus.excepttype_o, bus.flush_o, x_code[c], x_fl[c]);
      end
      if (bus.excepttype_o !== 32'd0 && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.current_inst_addr_o !== e.pc) begin
          n_fail++;
          $display("FAIL b2b_pc_%0d: got %h, required %h", c, bus.current_inst_addr_o, e.pc);
        end
      end
      if (c == 3) idle_inputs();
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int cyc; exp_t e;
    bus.cp0_status_i = 32'h0;
    bus.int_i        = 6'h3f;
    issue(9'h008, 32'h8000_0500, 1'b1, 32'h0000_5555);
    sb_q.push_back('{code: 32'h8, pc: 32'h8000_0500, bad: 32'h0000_5555, npc: VEC, ds: 1'b1});
    wait_commit(seen, cyc);
    n_tests++;
    if (!seen || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: no exception pulse before reset");
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if (bus.excepttype_o !== e.code) begin
        n_fail++;
        $display("FAIL reset_mid_code: got %h, required %h", bus.excepttype_o, e.code);
      end
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.int_sync_o, bus.excepttype_o, bus.current_inst_addr_o, bus.bad_addr_o,
         bus.is_in_delayslot_o, bus.flush_o, bus.new_pc_o} !== 136'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got sync=%b code=%h flush=%b npc=%h, required all zero",
               bus.int_sync_o, bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.int_i = 6'd0;
    n_tests++;
    if ({bus.excepttype_o, bus.flush_o, bus.new_pc_o} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_mid_release: got code=%h flush=%b npc=%h, required 0 0 0",
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end
    issue(9'h010, 32'h8000_0600, 1'b0, 32'h0);
    sb_q.push_back('{code: 32'h9, pc: 32'h8000_0600, bad: 32'h0, npc: VEC, ds: 1'b0});
    wait_commit(seen, cyc);
    n_tests++;
    if (!seen || cyc != 1 || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: seen=%0d cycles=%0d, required pulse after 1 cycle", seen, cyc);
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if ({bus.excepttype_o, bus.current_inst_addr_o} !== {e.code, e.pc}) begin
        n_fail++;
        $display("FAIL reset_mid_after: got code=%h pc=%h, required %h %h",
                 bus.excepttype_o, bus.current_inst_addr_o, e.code, e.pc);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst                       = 1'b0;
    bus.int_i                 = 6'd0;
    bus.mem_valid_i           = 1'b0;
    bus.mem_except_i          = 9'd0;
    bus.mem_pc_i              = 32'd0;
    bus.mem_is_in_delayslot_i = 1'b0;
    bus.mem_bad_addr_i        = 32'd0;
    bus.cp0_status_i          = 32'd0;
    bus.cp0_cause_i           = 32'd0;
    bus.cp0_epc_i             = 32'd0;
    test_reset();
    test_syscall();
    test_interrupt();
    test_priority();
    test_adel_fetch();
    test_eret();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected commits never seen, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
